// File: rtl/int_issue_exec.sv
// Single-entry integer issue/execute stage: accepts one ready entry from the issue queue,
// executes it on a small ALU and holds the tagged result until the CDB grants. Optional MUL via INT_MUL_EN.
module int_issue_exec #(
  parameter int unsigned DW      = 32,
  parameter int unsigned TAGW    = 6,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issueque_ready,
  input  logic [1:0]      data_sel,
  input  logic [2:0]      issue_opcode,
  input  logic [TAGW-1:0] issue_rd_tag,
  input  logic [DW-1:0]   issue_rs1_data,
  input  logic [DW-1:0]   issue_rs2_data,
  output logic            issueblk_done,
  output logic            cdb_req,
  input  logic            cdb_grant,
  output logic [TAGW-1:0] cdb_tag_out,
  output logic [DW-1:0]   cdb_data_out,
  output logic [1:0]      issued_slot,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(DW);
  localparam int unsigned CW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
`ifdef INT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [DW-1:0]   rs1_q, rs1_d;
  logic [DW-1:0]   rs2_q, rs2_d;
  logic [1:0]      slot_q, slot_d;
  logic            req_q, req_d;
  logic [TAGW-1:0] res_tag_q, res_tag_d;
  logic [DW-1:0]   res_q, res_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]   alu_res;
  logic [SHW-1:0]  shamt;
  logic            is_mul;
  logic            exec_done;

  assign shamt     = rs2_q[SHW-1:0];
  assign is_mul    = MUL_EN && (op_q == 3'b111);
  assign exec_done = !is_mul || (cnt_q == '0);

  // Result datapath on the captured operands
  always_comb begin
    alu_res = '0;
    case (op_q)
      3'b000: alu_res = rs1_q + rs2_q;
      3'b001: alu_res = rs1_q - rs2_q;
      3'b010: alu_res = rs1_q & rs2_q;
      3'b011: alu_res = rs1_q | rs2_q;
      3'b100: alu_res = rs1_q ^ rs2_q;
      3'b101: alu_res = DW'($signed(rs1_q) < $signed(rs2_q));
      3'b110: alu_res = rs1_q << shamt;
`ifdef INT_MUL_EN
      3'b111: alu_res = rs1_q * rs2_q;
`else
      3'b111: alu_res = rs1_q >> shamt;
`endif
      default: alu_res = '0;
    endcase
  end

  // Next-state and register-update logic
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    tag_d         = tag_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    slot_d        = slot_q;
    req_d         = req_q;
    res_tag_d     = res_tag_q;
    res_d         = res_q;
    busy_d        = busy_q;
    cnt_d         = cnt_q;
    issueblk_done = 1'b0;
    case (state_q)
      IDLE: begin
        issueblk_done = issueque_ready;
        if (issueque_ready) begin
          op_d    = issue_opcode;
          tag_d   = issue_rd_tag;
          rs1_d   = issue_rs1_data;
          rs2_d   = issue_rs2_data;
          slot_d  = data_sel;
          cnt_d   = CW'(MUL_LAT - 1);
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          res_d     = alu_res;
          res_tag_d = tag_q;
          req_d     = 1'b1;
          state_d   = WB;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WB: begin
        if (cdb_grant) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      slot_q    <= '0;
      req_q     <= 1'b0;
      res_tag_q <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      slot_q    <= slot_d;
      req_q     <= req_d;
      res_tag_q <= res_tag_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cdb_req      = req_q;
  assign cdb_tag_out  = res_tag_q;
  assign cdb_data_out = res_q;
  assign issued_slot  = slot_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_int_issue_exec.sv
// Directed, table-driven bench for int_issue_exec: per-opcode vectors plus
// backpressure, back-to-back issue and reset-mid-WB sequences.
module tb_int_issue_exec;

  localparam int unsigned DW      = 32;
  localparam int unsigned TAGW    = 6;
  localparam int unsigned MUL_LAT = 3;
`ifdef INT_MUL_EN
  localparam int OP7_LAT = 1 + MUL_LAT;
  localparam logic [31:0] OP7_A_EXP = 32'd42;
  localparam logic [31:0] OP7_B_EXP = 32'h8000_0000;
`else
  localparam int OP7_LAT = 2;
  localparam logic [31:0] OP7_A_EXP = 32'd0;
  localparam logic [31:0] OP7_B_EXP = 32'd1;
`endif

  logic            clk;
  logic            rst_n;
  logic            issueque_ready;
  logic [1:0]      data_sel;
  logic [2:0]      issue_opcode;
  logic [TAGW-1:0] issue_rd_tag;
  logic [DW-1:0]   issue_rs1_data;
  logic [DW-1:0]   issue_rs2_data;
  logic            issueblk_done;
  logic            cdb_req;
  logic            cdb_grant;
  logic [TAGW-1:0] cdb_tag_out;
  logic [DW-1:0]   cdb_data_out;
  logic [1:0]      issued_slot;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  int_issue_exec #(.DW(DW), .TAGW(TAGW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .issueque_ready(issueque_ready), .data_sel(data_sel),
    .issue_opcode(issue_opcode), .issue_rd_tag(issue_rd_tag),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issueblk_done(issueblk_done), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .cdb_tag_out(cdb_tag_out), .cdb_data_out(cdb_data_out),
    .issued_slot(issued_slot), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [1:0]  sel;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] tag, input logic [1:0] sel);
    issueque_ready = rdy;
    issue_opcode   = op;
    issue_rs1_data = a;
    issue_rs2_data = b;
    issue_rd_tag   = tag;
    data_sel       = sel;
  endtask

  // One instruction with grant tied high; measures accept-to-request latency
  task automatic run_vec(input vec_t v, input int idx);
    int cycle;
    @(posedge clk); #1;
    drive(1'b1, v.op, v.a, v.b, v.tag, v.sel);
    cdb_grant = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_done", idx), 32'(issueblk_done), 32'd1);
    @(posedge clk); #1;
    issueque_ready = 1'b0;
    data_sel = ~v.sel;
    cycle = 1;
    @(negedge clk);
    while (!cdb_req && cycle < 20) begin
      @(posedge clk); #1;
      cycle++;
      @(negedge clk);
    end
    check($sformatf("v%0d_lat", idx), 32'(cycle), 32'(v.lat));
    check($sformatf("v%0d_tag", idx), 32'(cdb_tag_out), 32'(v.tag));
    check($sformatf("v%0d_data", idx), cdb_data_out, v.exp);
    check($sformatf("v%0d_slot", idx), 32'(issued_slot), 32'(v.sel));
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("v%0d_req_drop", idx), 32'(cdb_req), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'd5,          32'd7,          6'd17, 2'd3, 32'd12,         2};
    vecs[1]  = '{3'b001, 32'd3,          32'd5,          6'd1,  2'd0, 32'hFFFF_FFFE,  2};
    vecs[2]  = '{3'b010, 32'hF0F0_00FF,  32'h0FF0_0F0F,  6'd2,  2'd1, 32'h00F0_000F,  2};
    vecs[3]  = '{3'b011, 32'hF000_0000,  32'h0000_000F,  6'd3,  2'd2, 32'hF000_000F,  2};
    vecs[4]  = '{3'b100, 32'hAAAA_5555,  32'hFFFF_0000,  6'd4,  2'd3, 32'h5555_5555,  2};
    vecs[5]  = '{3'b101, 32'hFFFF_FFFF,  32'd1,          6'd5,  2'd0, 32'd1,          2};
    vecs[6]  = '{3'b101, 32'd1,          32'hFFFF_FFFF,  6'd6,  2'd1, 32'd0,          2};
    vecs[7]  = '{3'b110, 32'd1,          32'd35,         6'd7,  2'd2, 32'd8,          2};
    vecs[8]  = '{3'b111, 32'd6,          32'd7,          6'd8,  2'd3, OP7_A_EXP,      OP7_LAT};
    vecs[9]  = '{3'b000, 32'hFFFF_FFFF,  32'd2,          6'd63, 2'd0, 32'd1,          2};
    vecs[10] = '{3'b111, 32'h8000_0000,  32'h0000_003F,  6'd10, 2'd1, OP7_B_EXP,      OP7_LAT};

    rst_n = 1'b0;
    cdb_grant = 1'b0;
    drive(1'b0, 3'b0, 32'd0, 32'd0, 6'd0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(cdb_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", cdb_data_out, 32'd0);
    check("rst_tag", 32'(cdb_tag_out), 32'd0);
    check("rst_slot", 32'(issued_slot), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_done_lo", 32'(issueblk_done), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Backpressure: grant withheld, queue keeps offering an entry
    @(posedge clk); #1;
    drive(1'b1, 3'b001, 32'd3, 32'd5, 6'd9, 2'd2);
    cdb_grant = 1'b0;
    @(negedge clk);
    check("bp_done0", 32'(issueblk_done), 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 3'b000, 32'd1, 32'd1, 6'd1, 2'd0);
    @(negedge clk);
    check("bp_c1_done", 32'(issueblk_done), 32'd0);
    check("bp_c1_req", 32'(cdb_req), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("bp_c%0d_req", c), 32'(cdb_req), 32'd1);
      check($sformatf("bp_c%0d_data", c), cdb_data_out, 32'hFFFF_FFFE);
      check($sformatf("bp_c%0d_tag", c), 32'(cdb_tag_out), 32'd9);
      check($sformatf("bp_c%0d_done", c), 32'(issueblk_done), 32'd0);
    end
    @(posedge clk); #1;
    cdb_grant = 1'b1;
    @(negedge clk);
    check("bp_c6_req", 32'(cdb_req), 32'd1);
    check("bp_c6_done", 32'(issueblk_done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_c7_req", 32'(cdb_req), 32'd0);
    check("bp_c7_busy", 32'(busy), 32'd0);
    check("bp_c7_done", 32'(issueblk_done), 32'd1);
    issueque_ready = 1'b0;

    // Back-to-back ready entries under immediate grant: 3-cycle issue spacing
    @(posedge clk); #1;
    drive(1'b1, 3'b000, 32'd1, 32'd1, 6'd12, 2'd1);
    cdb_grant = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("b2b_c%0d_done", c), 32'(issueblk_done), 32'((c % 3) == 0));
      if (c >= 1) check($sformatf("b2b_c%0d_slot", c), 32'(issued_slot), 32'd1);
      @(posedge clk); #1;
      data_sel = ((c + 1) % 3 == 0) ? 2'd1 : 2'd2;
    end
    issueque_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset asserted while a result waits in WB
    drive(1'b1, 3'b000, 32'd5, 32'd7, 6'd17, 2'd3);
    cdb_grant = 1'b0;
    @(posedge clk); #1;
    issueque_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rwb_req_before", 32'(cdb_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rwb_req", 32'(cdb_req), 32'd0);
    check("rwb_busy", 32'(busy), 32'd0);
    check("rwb_data", cdb_data_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issueque_ready = 1'b1;
    @(negedge clk);
    check("rwb_post_done", 32'(issueblk_done), 32'd1);
    check("rwb_post_busy", 32'(busy), 32'd0);
    issueque_ready = 1'b0;
    run_vec(vecs[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
